// File: rtl/bmem_burst_adapter_pkg.sv
// Shared constants and FSM state type for the cache-line to bmem burst adapter.
package bmem_adapter_pkg;

  localparam int BEAT_W      = 64;
  localparam int BURST_LEN   = 4;
  localparam int LINE_W      = BEAT_W * BURST_LEN;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_W       = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_BEAT,
    RESP,
    HOLD
  } state_e;

endpackage

// File: rtl/bmem_burst_adapter_if.sv
// Arbiter-side line interface and memory-side burst interface of the adapter.
interface bmem_line_if;
  import bmem_adapter_pkg::*;

  logic [31:0]       line_addr;
  logic              line_read;
  logic              line_write;
  logic [LINE_W-1:0] line_wdata;
  logic [LINE_W-1:0] line_rdata;
  logic              line_valid;

  modport master (
    output line_addr, line_read, line_write, line_wdata,
    input  line_rdata, line_valid
  );

  modport slave (
    input  line_addr, line_read, line_write, line_wdata,
    output line_rdata, line_valid
  );
endinterface

interface bmem_bus_if;
  import bmem_adapter_pkg::*;

  logic              bmem_ready;
  logic [31:0]       bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic [31:0]       bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );
endinterface

// File: rtl/bmem_burst_adapter_line_assembler.sv
// Beat counter and beat-indexed line buffer shared by read and write bursts.
module line_assembler
  import bmem_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              adv_i,
  input  logic              cap_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              last_o,
  output logic              full_o,
  output logic [LINE_W-1:0] line_o
);

  logic [CNT_W-1:0]                 cnt_q;
  logic                             full_q;
  logic [BURST_LEN-1:0][BEAT_W-1:0] buf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      buf_q  <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      if (cap_i) begin
        buf_q[cnt_q] <= beat_i;
        if (last_o) full_q <= 1'b1;
      end
      if (adv_i) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(BURST_LEN - 1));
  assign full_o = full_q;
  assign line_o = buf_q;

endmodule

// File: rtl/bmem_burst_adapter.sv
// Converts 256-bit cache-line requests into 4-beat bmem bursts and back.
// Optional BMEM_RADDR_CHECK_EN: drop read beats whose raddr tag is not this line.
module bmem_burst_adapter
  import bmem_adapter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  bmem_line_if.slave    line,
  bmem_bus_if.master    mem
);

  state_e state_q, state_d;

  logic [31:0]                      addr_q;
  logic [BURST_LEN-1:0][BEAT_W-1:0] wdata_q;
  logic                             latch_q_en;

  logic              clr, adv, cap, beat_ok;
  logic [CNT_W-1:0]  cnt;
  logic              last, full;
  logic [LINE_W-1:0] asm_line;

  line_assembler u_asm (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .adv_i  (adv),
    .cap_i  (cap),
    .beat_i (mem.bmem_rdata),
    .cnt_o  (cnt),
    .last_o (last),
    .full_o (full),
    .line_o (asm_line)
  );

`ifdef BMEM_RADDR_CHECK_EN
  assign beat_ok = (mem.bmem_raddr[31:OFFSET_BITS] == addr_q[31:OFFSET_BITS]);
`else
  logic unused_raddr;
  assign unused_raddr = ^mem.bmem_raddr;
  assign beat_ok      = 1'b1;
`endif

  logic unused_offset;
  assign unused_offset = ^line.line_addr[OFFSET_BITS-1:0];

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Request payload is only meaningful while a burst is active, so it is not reset.
  always_ff @(posedge clk) begin
    if (latch_q_en) begin
      addr_q  <= {line.line_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
      wdata_q <= line.line_wdata;
    end
  end

  always_comb begin
    state_d         = state_q;
    latch_q_en      = 1'b0;
    clr             = 1'b0;
    adv             = 1'b0;
    cap             = 1'b0;
    line.line_valid = 1'b0;
    line.line_rdata = '0;
    mem.bmem_addr   = '0;
    mem.bmem_read   = 1'b0;
    mem.bmem_write  = 1'b0;
    mem.bmem_wdata  = '0;

    case (state_q)
      IDLE: begin
        if (line.line_write && mem.bmem_ready) begin
          latch_q_en = 1'b1;
          clr        = 1'b1;
          state_d    = WR_BEAT;
        end else if (line.line_read && mem.bmem_ready) begin
          latch_q_en = 1'b1;
          state_d    = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem.bmem_read = 1'b1;
        mem.bmem_addr = addr_q;
        if (mem.bmem_ready) begin
          clr     = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem.bmem_rvalid && beat_ok) begin
          cap = 1'b1;
          adv = 1'b1;
          if (last) state_d = RESP;
        end
      end
      WR_BEAT: begin
        mem.bmem_write = 1'b1;
        mem.bmem_addr  = addr_q;
        mem.bmem_wdata = wdata_q[cnt];
        if (mem.bmem_ready) begin
          adv = 1'b1;
          if (last) state_d = RESP;
        end
      end
      RESP: begin
        // A write burst clears the assembler and never fills it, so full marks a read.
        line.line_valid = 1'b1;
        line.line_rdata = full ? asm_line : '0;
        state_d         = HOLD;
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bmem_burst_adapter.sv
// Directed bench for bmem_burst_adapter: read, write, backpressure, priority, reset.
module tb_bmem_burst_adapter;
  import bmem_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  bmem_line_if lif ();
  bmem_bus_if  bif ();

  bmem_burst_adapter dut (
    .clk  (clk),
    .rst  (rst),
    .line (lif.slave),
    .mem  (bif.master)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0 = 64'hA0A0_0000_0000_00D0;
  localparam logic [63:0] D1 = 64'hA1A1_0000_0000_00D1;
  localparam logic [63:0] D2 = 64'hA2A2_0000_0000_00D2;
  localparam logic [63:0] D3 = 64'hA3A3_0000_0000_00D3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".line_valid"}, 256'(lif.line_valid), 256'(0));
    chk({tag, ".line_rdata"}, lif.line_rdata, 256'(0));
    chk({tag, ".bmem_read"},  256'(bif.bmem_read), 256'(0));
    chk({tag, ".bmem_write"}, 256'(bif.bmem_write), 256'(0));
    chk({tag, ".bmem_addr"},  256'(bif.bmem_addr), 256'(0));
    chk({tag, ".bmem_wdata"}, 256'(bif.bmem_wdata), 256'(0));
  endtask

  task automatic beat(input logic [63:0] d, input logic [31:0] tag);
    bif.bmem_rvalid = 1'b1;
    bif.bmem_rdata  = d;
    bif.bmem_raddr  = tag;
    tick();
    bif.bmem_rvalid = 1'b0;
  endtask

  initial begin
    lif.line_addr   = '0;
    lif.line_read   = 1'b0;
    lif.line_write  = 1'b0;
    lif.line_wdata  = '0;
    bif.bmem_ready  = 1'b0;
    bif.bmem_raddr  = '0;
    bif.bmem_rdata  = '0;
    bif.bmem_rvalid = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b1;
    bif.bmem_ready = 1'b1;

    // Read with one retry cycle and a stray beat during RD_ISSUE
    lif.line_read = 1'b1;
    lif.line_addr = 32'h1000_0024;
    tick();
    lif.line_read = 1'b0;
    chk("rd.issue.read", 256'(bif.bmem_read), 256'(1));
    chk("rd.issue.addr", 256'(bif.bmem_addr), 256'(32'h1000_0020));
    bif.bmem_ready  = 1'b0;
    bif.bmem_rvalid = 1'b1;
    bif.bmem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    chk("rd.retry.read", 256'(bif.bmem_read), 256'(1));
    bif.bmem_ready  = 1'b1;
    bif.bmem_rvalid = 1'b0;
    tick();
    chk("rd.wait.read", 256'(bif.bmem_read), 256'(0));
    beat(B0, 32'h1000_0020);
    beat(B1, 32'h1000_0020);
    tick();
    beat(B2, 32'h1000_0020);
    chk("rd.beforelast.valid", 256'(lif.line_valid), 256'(0));
    beat(B3, 32'h1000_0020);
    chk("rd.resp.valid", 256'(lif.line_valid), 256'(1));
    chk("rd.resp.data", lif.line_rdata, {B3, B2, B1, B0});
    tick();
    chk("rd.hold.valid", 256'(lif.line_valid), 256'(0));
    tick();

    // Write with backpressure on beats 1 and 3; read request raised during RESP/HOLD
    lif.line_write = 1'b1;
    lif.line_addr  = 32'h2000_0040;
    lif.line_wdata = {D3, D2, D1, D0};
    tick();
    lif.line_write = 1'b0;
    chk("wr.b0.write", 256'(bif.bmem_write), 256'(1));
    chk("wr.b0.addr", 256'(bif.bmem_addr), 256'(32'h2000_0040));
    chk("wr.b0.data", 256'(bif.bmem_wdata), 256'(D0));
    tick();
    bif.bmem_ready = 1'b0;
    chk("wr.b1.data", 256'(bif.bmem_wdata), 256'(D1));
    tick();
    chk("wr.b1stall.write", 256'(bif.bmem_write), 256'(1));
    chk("wr.b1stall.data", 256'(bif.bmem_wdata), 256'(D1));
    bif.bmem_ready = 1'b1;
    tick();
    chk("wr.b2.data", 256'(bif.bmem_wdata), 256'(D2));
    chk("wr.b2.addr", 256'(bif.bmem_addr), 256'(32'h2000_0040));
    tick();
    bif.bmem_ready = 1'b0;
    chk("wr.b3.data", 256'(bif.bmem_wdata), 256'(D3));
    tick();
    chk("wr.b3stall.data", 256'(bif.bmem_wdata), 256'(D3));
    chk("wr.b3stall.valid", 256'(lif.line_valid), 256'(0));
    bif.bmem_ready = 1'b1;
    tick();
    chk("wr.resp.valid", 256'(lif.line_valid), 256'(1));
    chk("wr.resp.rdata", lif.line_rdata, 256'(0));
    chk("wr.resp.write", 256'(bif.bmem_write), 256'(0));
    lif.line_read = 1'b1;
    lif.line_addr = 32'h7000_0000;
    tick();
    chk("wr.hold.valid", 256'(lif.line_valid), 256'(0));
    chk("wr.hold.read", 256'(bif.bmem_read), 256'(0));
    tick();
    chk("wr.afterhold.read", 256'(bif.bmem_read), 256'(0));
    lif.line_read = 1'b0;
    tick();

    // Simultaneous read and write: write wins, full-speed latency
    lif.line_read  = 1'b1;
    lif.line_write = 1'b1;
    lif.line_addr  = 32'h3000_001F;
    lif.line_wdata = {D0, D1, D2, D3};
    tick();
    lif.line_read  = 1'b0;
    lif.line_write = 1'b0;
    chk("sim.c1.write", 256'(bif.bmem_write), 256'(1));
    chk("sim.c1.read", 256'(bif.bmem_read), 256'(0));
    chk("sim.c1.addr", 256'(bif.bmem_addr), 256'(32'h3000_0000));
    chk("sim.c1.data", 256'(bif.bmem_wdata), 256'(D3));
    tick();
    chk("sim.c2.data", 256'(bif.bmem_wdata), 256'(D2));
    tick();
    chk("sim.c3.data", 256'(bif.bmem_wdata), 256'(D1));
    tick();
    chk("sim.c4.data", 256'(bif.bmem_wdata), 256'(D0));
    chk("sim.c4.read", 256'(bif.bmem_read), 256'(0));
    tick();
    chk("sim.c5.valid", 256'(lif.line_valid), 256'(1));
    chk("sim.c5.write", 256'(bif.bmem_write), 256'(0));
    tick();
    tick();

    // Reset in the middle of a read, then a clean read
    lif.line_read = 1'b1;
    lif.line_addr = 32'h4000_0000;
    tick();
    lif.line_read = 1'b0;
    tick();
    beat(64'hBAD0, 32'h4000_0000);
    beat(64'hBAD1, 32'h4000_0000);
    rst = 1'b0;
    tick();
    chk_idle_outputs("rstmid");
    rst = 1'b1;
    beat(64'hBAD2, 32'h4000_0000);
    chk("rstmid.b2.valid", 256'(lif.line_valid), 256'(0));
    beat(64'hBAD3, 32'h4000_0000);
    chk("rstmid.b3.valid", 256'(lif.line_valid), 256'(0));
    chk("rstmid.b3.read", 256'(bif.bmem_read), 256'(0));
    lif.line_read = 1'b1;
    lif.line_addr = 32'h5000_0008;
    tick();
    lif.line_read = 1'b0;
    chk("rd2.issue.addr", 256'(bif.bmem_addr), 256'(32'h5000_0000));
    tick();
    beat(B3, 32'h5000_0000);
    beat(B0, 32'h5000_0000);
    beat(B2, 32'h5000_0000);
    beat(B1, 32'h5000_0000);
    chk("rd2.resp.valid", 256'(lif.line_valid), 256'(1));
    chk("rd2.resp.data", lif.line_rdata, {B1, B2, B0, B3});
    tick();
    tick();

`ifdef BMEM_RADDR_CHECK_EN
    // Foreign-tagged beat is dropped without advancing the beat index
    lif.line_read = 1'b1;
    lif.line_addr = 32'h6000_0040;
    tick();
    lif.line_read = 1'b0;
    tick();
    beat(B0, 32'h6000_0040);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 32'h6000_0060);
    beat(B1, 32'h6000_005C);
    beat(B2, 32'h6000_0040);
    chk("rchk.beforelast.valid", 256'(lif.line_valid), 256'(0));
    beat(B3, 32'h6000_0040);
    chk("rchk.resp.valid", 256'(lif.line_valid), 256'(1));
    chk("rchk.resp.data", lif.line_rdata, {B3, B2, B1, B0});
    tick();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bmem_burst_adapter.md
Name: bmem_burst_adapter

Overview:
- Sits directly downstream of the I/D cache arbiter, between it and the banked burst memory model.
- Converts one 256-bit cache-line request into a BURST_LEN-beat transaction of BEAT_W-bit beats on the bmem interface.
  - Reads: one read command, then reassembles the returned beats into a line.
  - Writes: streams the line out as beats.
- Returns the assembled line, or a write acknowledge, to the arbiter as a single-cycle valid pulse.

Parameters:
- BEAT_W, 64, bmem data beat width in bits.
- BURST_LEN, 4, beats per line; LINE_W = BEAT_W*BURST_LEN = 256.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; block is in reset while rst==0.
- line_addr  in  32  line address from arbiter; bits [4:0] ignored, forwarded with [4:0]=0.
- line_read  in  1  read request; sampled only in IDLE.
- line_write  in  1  write request (level); sampled only in IDLE.
- line_wdata  in  LINE_W  write line; beat k = line_wdata[k*BEAT_W +: BEAT_W].
- bmem_ready  in  1  memory can accept a command/beat this cycle.
- line_rdata  out  LINE_W  assembled read line; valid only while line_valid==1.
- line_valid  out  1  one-cycle completion pulse (read data or write ack).
- bmem_addr  out  32  command address.
- bmem_read  out  1  read command, one cycle.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  BEAT_W  write beat.
- bmem_raddr  in  32  address tag of the returning read beat.
- bmem_rdata  in  BEAT_W  returning read beat.
- bmem_rvalid  in  1  read beat valid.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, beat counter=0, line buffer=0.
  - All outputs 0: line_valid, line_rdata, bmem_read, bmem_write, bmem_addr, bmem_wdata.
  - Reset wins over any in-flight burst; beats arriving afterwards are ignored in IDLE.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_BEAT, RESP, HOLD.
- IDLE:
  - line_write has priority over line_read.
  - line_write & bmem_ready: latch addr and wdata -> WR_BEAT, cnt=0.
  - else line_read & bmem_ready: latch addr -> RD_ISSUE.
  - Neither request, or bmem_ready==0: stay in IDLE.
- RD_ISSUE:
  - bmem_read=1, bmem_addr=latched addr.
  - bmem_ready=1: -> RD_WAIT, cnt=0.
  - bmem_ready=0: hold the command (retry next cycle).
- RD_WAIT:
  - On bmem_rvalid: buffer[cnt*BEAT_W +: BEAT_W] = bmem_rdata, cnt++.
  - When the beat with cnt==BURST_LEN-1 is captured: -> RESP.
  - Gaps between beats are allowed; no timeout.
- WR_BEAT:
  - bmem_write=1, bmem_addr=latched addr (held for all beats), bmem_wdata=beat cnt.
  - Beat is consumed only when bmem_ready=1: cnt++.
  - Last beat consumed: -> RESP.
- RESP:
  - line_valid=1 for exactly one cycle.
  - line_rdata=buffer after a read; 0 after a write.
  - -> HOLD.
- HOLD:
  - One cycle, all requests ignored, so the arbiter's registered request can deassert.
  - -> IDLE.
- Latency (bmem_ready held high):
  - Read: line_valid 1 cycle after the last rvalid beat.
  - Write: line_valid 1 cycle after the 4th beat is accepted (request accepted at cycle 0 -> beats cycles 1-4 -> line_valid cycle 5).
- Boundaries:
  - line_read & line_write together: write serviced, read ignored.
  - bmem_rvalid outside RD_WAIT: dropped.
  - cnt wraps to 0 on each burst start.

Optional Feature:
- Macro BMEM_RADDR_CHECK_EN.
  - Defined: in RD_WAIT a beat is captured only if bmem_raddr[31:5]==latched addr[31:5]; mismatching beats are dropped without advancing cnt.
  - Undefined: every bmem_rvalid beat in RD_WAIT is captured; bmem_raddr is unused.

Decomposition:
- Package bmem_adapter_pkg holds:
  - the state enum typedef;
  - constants BEAT_W=64, BURST_LEN=4, LINE_W=256, OFFSET_BITS=5.
- One sub-module, line_assembler: beat-indexed buffer write, cnt, clear on burst start, full flag.

Test Plan:
- Read, bmem_ready=1: line_read, addr 0x1000_0024 -> bmem_read 1 cycle with addr 0x1000_0020; beats 0x11..,0x22..,0x33..,0x44.. -> line_valid 1 cycle with line_rdata = {0x44..,0x33..,0x22..,0x11..}.
- Write: line_write, addr 0x2000_0040, line_wdata = {D3,D2,D1,D0} -> bmem_write 4 cycles carrying D0..D3, addr 0x2000_0040 on every beat; line_valid on cycle 5; inputs ignored on cycle 6 (HOLD).
- Backpressure: bmem_ready low during write beats 1 and 3 -> beat data held, no beat skipped or repeated, exactly 4 accepted beats.
- Simultaneous: line_read and line_write both high in IDLE -> write burst only; no bmem_read issued.
- Reset (rst=0) mid read after 2 beats -> all outputs 0 next cycle; remaining beats ignored; a new read completes correctly.
- BMEM_RADDR_CHECK_EN defined: interleave a beat with foreign bmem_raddr -> beat dropped; line assembled from matching beats only.
